h2f_burst_regfile: RTL and testbench

Parametrised Avalon-MM slave register file behind the HPS-to-FPGA bridge. It replaces the single-beat, fixed-64-bit register bridge with one that adds the following:
- configurable width and depth
- byte-enabled burst writes
- pipelined burst reads with fixed latency
- per-register read-only (fabric-owned) status registers
- per-register write-strobe outputs
The fabric gets a random-access read port plus a write port into the status registers.

---
 rtl/h2f_burst_regfile.sv | 124 ++++++++++++
 tb/tb_h2f_burst_regfile.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h2f_burst_regfile.sv
// h2f_burst_regfile: Avalon-MM burst register file behind the HPS-to-FPGA bridge.
// Host side: read/write/address/writedata/byteenable/burstcount in, readdata/readdatavalid/waitrequest out.
// Fabric side: fabric_regsel_i -> fabric_regdata_o (combinational), fabric_wr_i/fabric_wrsel_i/fabric_wrdata_i
// into RO_MASK registers, wr_pulse_o one-cycle strobe per host-written register.
// Optional H2F_REGFILE_ERR_EN adds sticky err_o; the last register then becomes a write-1-to-clear command.
module h2f_burst_regfile #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32,
  parameter int BURST_W = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read,
  input  logic                        write,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           writedata,
  input  logic [DATA_W/8-1:0]         byteenable,
  input  logic [BURST_W-1:0]          burstcount,
  output logic [DATA_W-1:0]           readdata,
  output logic                        readdatavalid,
  output logic                        waitrequest,
  input  logic [$clog2(NUM_REGS)-1:0] fabric_regsel_i,
  output logic [DATA_W-1:0]           fabric_regdata_o,
  input  logic                        fabric_wr_i,
  input  logic [$clog2(NUM_REGS)-1:0] fabric_wrsel_i,
  input  logic [DATA_W-1:0]           fabric_wrdata_i,
  output logic [NUM_REGS-1:0]         wr_pulse_o
`ifdef H2F_REGFILE_ERR_EN
  ,
  output logic                        err_o
`endif
);
  localparam int OFF = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(NUM_REGS);
  // wide enough that a burst running past the top never wraps back in range
  localparam int IW = ADDR_W + BURST_W;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, addr_idx, beat_idx, s1_idx_q, s1_idx_d;
  logic [BURST_W-1:0] cnt_q, cnt_d, req_cnt;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic readdatavalid_q, readdatavalid_d, s1_v_q, s1_v_d;
  logic acc, wr_beat, rd_beat, in_rng, wen, store;
`ifdef H2F_REGFILE_ERR_EN
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  logic err_q, err_d, cmd;
  assign err_o = err_q;
`endif
  assign waitrequest = rst | (state_q == RD_BURST);
  assign readdata = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign wr_pulse_o = wr_pulse_q;
  assign fabric_regdata_o = regs_q[fabric_regsel_i];
  always_comb begin
    addr_idx = IW'(address) >> OFF;
    req_cnt = (burstcount == '0) ? BURST_W'(1) : burstcount;
    acc = (read | write) & ~waitrequest;
    wr_beat = (state_q == IDLE) ? acc & write : (state_q == WR_BURST) & write;
    rd_beat = (state_q == IDLE) ? acc & ~write : (state_q == RD_BURST);
    beat_idx = (state_q == IDLE) ? addr_idx : idx_q;
    in_rng = beat_idx < IW'(NUM_REGS);
    wen = wr_beat & in_rng & ~RO_MASK[beat_idx[IDX_W-1:0]];
    idx_d = idx_q;
    cnt_d = cnt_q;
    state_d = state_q;
    // beat 1 of every command issues in the accepting IDLE cycle
    if (wr_beat | rd_beat) begin
      idx_d = beat_idx + IW'(1);
      cnt_d = ((state_q == IDLE) ? req_cnt : cnt_q) - BURST_W'(1);
      state_d = (cnt_d == '0) ? IDLE : (state_q != IDLE) ? state_q : write ? WR_BURST : RD_BURST;
    end
`ifdef H2F_REGFILE_ERR_EN
    cmd = wen & (beat_idx == LAST);
    store = wen & ~cmd;
    err_d = (cmd & byteenable[0] & writedata[0]) ? 1'b0 : err_q | (wr_beat & ~wen) | (rd_beat & ~in_rng);
`else
    store = wen;
`endif
    regs_d = regs_q;
    wr_pulse_d = '0;
    wr_pulse_d[beat_idx[IDX_W-1:0]] = wen;
    for (int b = 0; b < DATA_W/8; b++)
      if (store & byteenable[b]) regs_d[beat_idx[IDX_W-1:0]][8*b +: 8] = writedata[8*b +: 8];
    if (fabric_wr_i & RO_MASK[fabric_wrsel_i]) regs_d[fabric_wrsel_i] = fabric_wrdata_i;
    s1_v_d = rd_beat;
    s1_idx_d = beat_idx;
    readdatavalid_d = s1_v_q;
    readdata_d = (s1_v_q && s1_idx_q < IW'(NUM_REGS)) ? regs_q[s1_idx_q[IDX_W-1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      s1_v_q <= 1'b0;
      s1_idx_q <= '0;
      readdata_q <= '0;
      readdatavalid_q <= 1'b0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef H2F_REGFILE_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      s1_v_q <= s1_v_d;
      s1_idx_q <= s1_idx_d;
      readdata_q <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q <= regs_d;
`ifdef H2F_REGFILE_ERR_EN
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_h2f_burst_regfile.sv
// tb_h2f_burst_regfile: randomized self-checking bench for h2f_burst_regfile against a register-array model.
module tb_h2f_burst_regfile;
  localparam int AW = 10, DW = 64, NR = 32, BW = 4;
  localparam logic [NR-1:0] RO = 32'h0000_0204;
  logic clk = 1'b0, rst, read, write, readdatavalid, waitrequest, fabric_wr_i;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata, readdata, fabric_regdata_o, fabric_wrdata_i;
  logic [7:0] byteenable;
  logic [BW-1:0] burstcount;
  logic [4:0] fabric_regsel_i, fabric_wrsel_i;
  logic [NR-1:0] wr_pulse_o;
`ifdef H2F_REGFILE_ERR_EN
  logic err_o;
`endif
  int total = 0, bad = 0;
  logic [63:0] model [NR];
  logic [63:0] wd_a [8];
  logic [7:0] be_a [8];
  int gap_a [8];
  logic [63:0] got [$];
  int got_j [$];
  int wait_hi;

  h2f_burst_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BURST_W(BW), .RO_MASK(RO)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address), .writedata(writedata),
    .byteenable(byteenable), .burstcount(burstcount), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .fabric_regsel_i(fabric_regsel_i), .fabric_regdata_o(fabric_regdata_o),
    .fabric_wr_i(fabric_wr_i), .fabric_wrsel_i(fabric_wrsel_i), .fabric_wrdata_i(fabric_wrdata_i),
    .wr_pulse_o(wr_pulse_o)
`ifdef H2F_REGFILE_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_rd(int r);
    return (r < NR) ? model[r] : 64'h0;
  endfunction

  function automatic bit writable(int r);
    if (r >= NR || RO[r]) return 1'b0;
`ifdef H2F_REGFILE_ERR_EN
    if (r == NR - 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic model_wr(int r, logic [63:0] d, logic [7:0] be);
    if (writable(r))
      for (int b = 0; b < 8; b++) if (be[b]) model[r][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(int idx, int n);
    for (int k = 0; k < n; k++) begin
      write = 1'b0;
      repeat (gap_a[k]) begin @(posedge clk); #1; end
      write = 1'b1;
      address = AW'((idx + k) * 8);
      writedata = wd_a[k];
      byteenable = be_a[k];
      burstcount = BW'(n);
      @(posedge clk); #1;
      write = 1'b0;
      model_wr(idx + k, wd_a[k], be_a[k]);
    end
  endtask

  task automatic do_read(int idx, int n, int bc);
    got.delete();
    got_j.delete();
    wait_hi = 0;
    read = 1'b1;
    address = AW'(idx * 8);
    burstcount = BW'(bc);
    @(posedge clk); #1;
    read = 1'b0;
    for (int j = 1; j <= n + 5; j++) begin
      @(negedge clk);
      if (readdatavalid) begin got.push_back(readdata); got_j.push_back(j); end
      if (waitrequest) wait_hi++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0; burstcount = '0;
    fabric_regsel_i = '0; fabric_wr_i = 1'b0; fabric_wrsel_i = '0; fabric_wrdata_i = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL rst_waitreq got=%b exp=1", waitrequest); end
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b exp=0", readdatavalid); end
    total++; if (readdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", readdata); end
    total++; if (wr_pulse_o !== 32'h0) begin bad++; $display("FAIL rst_pulse got=%h exp=0", wr_pulse_o); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL rel_waitreq got=%b exp=0", waitrequest); end
    fabric_regsel_i = 5'd3; #1;
    total++; if (fabric_regdata_o !== 64'h0) begin bad++; $display("FAIL rst_reg3 got=%h exp=0", fabric_regdata_o); end
`ifdef H2F_REGFILE_ERR_EN
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    write = 1'b1; address = AW'(3 * 8); writedata = 64'h1122334455667788; byteenable = 8'hFF; burstcount = BW'(1);
    @(posedge clk); #1;
    write = 1'b0;
    model_wr(3, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    total++; if (wr_pulse_o !== 32'h8) begin bad++; $display("FAIL pulse_on got=%h exp=8", wr_pulse_o); end
    @(negedge clk);
    total++; if (wr_pulse_o !== 32'h0) begin bad++; $display("FAIL pulse_off got=%h exp=0", wr_pulse_o); end
    @(posedge clk); #1;
    do_read(3, 1, 1);
    total++; if (got.size() != 1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 64'h1122334455667788) begin bad++; $display("FAIL single_data got=%h exp=1122334455667788", got[0]); end
      total++; if (got_j[0] != 2) begin bad++; $display("FAIL single_lat got=%0d exp=2", got_j[0]); end
    end
  endtask

  task automatic test_burst;
    for (int k = 0; k < 4; k++) begin wd_a[k] = {$urandom, $urandom}; be_a[k] = 8'hFF; gap_a[k] = 0; end
    gap_a[2] = 2;
    do_write(4, 4);
    for (int k = 0; k < 4; k++) begin
      fabric_regsel_i = 5'(4 + k); #1;
      total++; if (fabric_regdata_o !== wd_a[k]) begin bad++; $display("FAIL burst_wr%0d got=%h exp=%h", k, fabric_regdata_o, wd_a[k]); end
    end
    do_read(4, 4, 4);
    total++; if (got.size() != 4) begin bad++; $display("FAIL burst_cnt got=%0d exp=4", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] !== model[4 + k] || got_j[k] != k + 2) begin bad++; $display("FAIL burst_rd%0d got=%h@%0d exp=%h@%0d", k, got[k], got_j[k], model[4 + k], k + 2); end
    end
    total++; if (wait_hi != 3) begin bad++; $display("FAIL burst_waitreq got=%0d exp=3", wait_hi); end
  endtask

  task automatic test_byteenable;
    wd_a[0] = '1; be_a[0] = 8'hFF; gap_a[0] = 0;
    do_write(1, 1);
    wd_a[0] = '0; be_a[0] = 8'h0F;
    do_write(1, 1);
    fabric_regsel_i = 5'd1; #1;
    total++; if (fabric_regdata_o !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL byteen got=%h exp=ffffffff00000000", fabric_regdata_o); end
  endtask

  task automatic test_ro;
    write = 1'b1; address = AW'(2 * 8); writedata = 64'h5555; byteenable = 8'hFF; burstcount = BW'(1);
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk);
    total++; if (wr_pulse_o !== 32'h0) begin bad++; $display("FAIL ro_pulse got=%h exp=0", wr_pulse_o); end
    fabric_regsel_i = 5'd2; #1;
    total++; if (fabric_regdata_o !== 64'h0) begin bad++; $display("FAIL ro_host got=%h exp=0", fabric_regdata_o); end
    @(posedge clk); #1;
    fabric_wr_i = 1'b1; fabric_wrsel_i = 5'd2; fabric_wrdata_i = 64'hABCD;
    @(posedge clk); #1;
    fabric_wrsel_i = 5'd5; fabric_wrdata_i = 64'hDEAD;
    @(posedge clk); #1;
    fabric_wr_i = 1'b0;
    model[2] = 64'hABCD;
    do_read(2, 1, 1);
    total++; if (got.size() != 1 || got[0] !== 64'hABCD) begin bad++; $display("FAIL ro_read got=%h n=%0d exp=abcd", got.size() > 0 ? got[0] : 64'h0, got.size()); end
    fabric_regsel_i = 5'd2; #1;
    total++; if (fabric_regdata_o !== 64'hABCD) begin bad++; $display("FAIL ro_fabric got=%h exp=abcd", fabric_regdata_o); end
    fabric_regsel_i = 5'd5; #1;
    total++; if (fabric_regdata_o !== model[5]) begin bad++; $display("FAIL rw_fabric_wr got=%h exp=%h", fabric_regdata_o, model[5]); end
  endtask

  task automatic test_oor;
    for (int k = 0; k < 2; k++) begin wd_a[k] = {$urandom, $urandom}; be_a[k] = 8'hFF; gap_a[k] = 0; end
    do_write(NR - 2, 2);
`ifdef H2F_REGFILE_ERR_EN
    wd_a[0] = 64'h1; be_a[0] = 8'h01;
    do_write(NR - 1, 1);
    @(negedge clk);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clr1 got=%b exp=0", err_o); end
    @(posedge clk); #1;
`endif
    do_read(NR - 2, 4, 4);
    total++; if (got.size() != 4) begin bad++; $display("FAIL oor_cnt got=%0d exp=4", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] !== exp_rd(NR - 2 + k)) begin bad++; $display("FAIL oor_rd%0d got=%h exp=%h", k, got[k], exp_rd(NR - 2 + k)); end
    end
`ifdef H2F_REGFILE_ERR_EN
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err_o); end
    wd_a[0] = 64'h1; be_a[0] = 8'h01;
    do_write(NR - 1, 1);
    @(negedge clk);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clr2 got=%b exp=0", err_o); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 4; k++) begin wd_a[k] = {$urandom, $urandom}; be_a[k] = 8'hFF; gap_a[k] = 0; end
    do_write(8, 4);
    read = 1'b1; address = AW'(8 * 8); burstcount = BW'(4);
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (readdatavalid !== 1'b1 || readdata !== model[8]) begin bad++; $display("FAIL mid_beat1 got=%b/%h exp=1/%h", readdatavalid, readdata, model[8]); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL mid_flush got=%b exp=0", readdatavalid); end
    total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL mid_waitreq got=%b exp=1", waitrequest); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    total++; if (readdatavalid !== 1'b0 || waitrequest !== 1'b0) begin bad++; $display("FAIL mid_after got=%b/%b exp=0/0", readdatavalid, waitrequest); end
    @(posedge clk); #1;
    wd_a[0] = {$urandom, $urandom}; be_a[0] = 8'hFF;
    do_write(9, 1);
    do_read(9, 1, 1);
    total++; if (got.size() != 1 || got[0] !== model[9]) begin bad++; $display("FAIL mid_reread got=%h n=%0d exp=%h", got.size() > 0 ? got[0] : 64'h0, got.size(), model[9]); end
  endtask

  task automatic test_back_to_back;
    bit done = 1'b0;
    for (int k = 0; k < 3; k++) begin wd_a[k] = {$urandom, $urandom}; be_a[k] = 8'hFF; gap_a[k] = 0; end
    do_write(4, 3);
    for (int k = 0; k < 3; k++) wd_a[k] = {$urandom, $urandom};
    do_write(12, 3);
    got.delete();
    got_j.delete();
    read = 1'b1; address = AW'(4 * 8); burstcount = BW'(3);
    @(posedge clk); #1;
    address = AW'(12 * 8);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (readdatavalid) begin got.push_back(readdata); got_j.push_back(j); end
      if (!done && !waitrequest) begin done = 1'b1; @(posedge clk); #1 read = 1'b0; end
    end
    read = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL b2b_accept got=timeout exp=accept"); end
    total++; if (got.size() != 6) begin bad++; $display("FAIL b2b_cnt got=%0d exp=6", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      total++; if (got[k] !== model[k < 3 ? 4 + k : 9 + k]) begin bad++; $display("FAIL b2b_rd%0d got=%h exp=%h", k, got[k], model[k < 3 ? 4 + k : 9 + k]); end
    end
    if (got.size() == 6) begin
      total++; if (got_j[5] - got_j[0] != 5) begin bad++; $display("FAIL b2b_gap got=%0d exp=5", got_j[5] - got_j[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      int op = $urandom_range(0, 2);
      int idx = $urandom_range(0, 35);
      int n = $urandom_range(1, 8);
      if (op == 0) begin
        for (int k = 0; k < n; k++) begin
          wd_a[k] = {$urandom, $urandom}; be_a[k] = 8'($urandom); gap_a[k] = (k == 0) ? 0 : $urandom_range(0, 2);
        end
        do_write(idx, n);
      end else if (op == 1) begin
        int bc = (n == 1 && $urandom_range(0, 1) == 1) ? 0 : n;
        do_read(idx, n, bc);
        total++; if (got.size() != n) begin bad++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", it, got.size(), n); end
        for (int k = 0; k < got.size(); k++) begin
          total++; if (got[k] !== exp_rd(idx + k)) begin bad++; $display("FAIL rnd_rd it=%0d idx=%0d got=%h exp=%h", it, idx + k, got[k], exp_rd(idx + k)); end
        end
      end else begin
        fabric_wr_i = 1'b1; fabric_wrsel_i = 5'($urandom); fabric_wrdata_i = {$urandom, $urandom};
        if (RO[fabric_wrsel_i]) model[fabric_wrsel_i] = fabric_wrdata_i;
        @(posedge clk); #1;
        fabric_wr_i = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) begin
      fabric_regsel_i = 5'(i); #1;
      total++; if (fabric_regdata_o !== model[i]) begin bad++; $display("FAIL rnd_final reg=%0d got=%h exp=%h", i, fabric_regdata_o, model[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_byteenable();
    test_ro();
    test_oor();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
